// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg
//   Shared definitions for the instruction fetch stage: opcode constants,
//   fetch FSM state encodings and the IF/ID bubble value.
package fetch_unit_pkg;

  // Halt opcode, found in instruction bits [15:12].
  localparam logic [3:0] OP_HLT = 4'hF;

  // Bubble word, written into IF/ID whenever no real instruction is present.
  localparam logic [15:0] BUBBLE = 16'h0000;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_WAIT = 2'd1,  // cache miss outstanding
    ST_HALT = 2'd2
  } fetch_state_t;

  function automatic logic is_hlt(input logic [15:0] word);
    return word[15:12] == OP_HLT;
  endfunction

endpackage

// File: rtl/fetch_unit_if_id_reg.sv
// if_id_reg
//   IF/ID pipeline register: instruction, its PC+1 and a valid bit.
//   Ports:
//     clk, rst_n        clock, synchronous active-low reset
//     bubble            write BUBBLE and clear valid (highest priority)
//     hold              keep current contents
//     load              capture new_instr / new_pc_plus1 with valid=1
//     new_instr         instruction word to capture
//     new_pc_plus1      PC+1 of new_instr
//     instr, pc_plus1, valid   registered outputs to decode
module if_id_reg
  import fetch_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        bubble,
  input  logic        hold,
  input  logic        load,
  input  logic [15:0] new_instr,
  input  logic [15:0] new_pc_plus1,
  output logic [15:0] instr,
  output logic [15:0] pc_plus1,
  output logic        valid
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      instr    <= BUBBLE;
      pc_plus1 <= 16'h0000;
      valid    <= 1'b0;
    end else if (bubble) begin
      // pc_plus1 is left as is: it is meaningless while valid is low.
      instr <= BUBBLE;
      valid <= 1'b0;
    end else if (!hold && load) begin
      instr    <= new_instr;
      pc_plus1 <= new_pc_plus1;
      valid    <= 1'b1;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit
//   Instruction fetch stage: PC, RUN/WAIT/HALT fetch FSM and the IF/ID
//   register.
//   Ports:
//     clk, rst_n          clock, synchronous active-low reset
//     stall_if            hold PC, FSM and IF/ID
//     redirect_en         load redirect_pc (overrides everything but reset)
//     redirect_pc         redirect target word address
//     i_rdy, i_data       instruction cache hit and its data
//     i_rd_en, i_addr     instruction read request and address (= PC)
//     if_id_instr         registered instruction to decode
//     if_id_pc_plus1      registered PC+1 of if_id_instr
//     if_id_valid         if_id_instr is a real instruction
//     halted              registered, high exactly while in HALT
module fetch_unit
  import fetch_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_if,
  input  logic        redirect_en,
  input  logic [15:0] redirect_pc,
  input  logic        i_rdy,
  input  logic [15:0] i_data,
  output logic        i_rd_en,
  output logic [15:0] i_addr,
  output logic [15:0] if_id_instr,
  output logic [15:0] if_id_pc_plus1,
  output logic        if_id_valid,
  output logic        halted
);

  fetch_state_t state;
  logic [15:0]  pc;
  logic [15:0]  pc_plus1;
  logic         fetching;
  logic         ifid_bubble;
  logic         ifid_load;

  assign pc_plus1 = pc + 16'd1;  // wraps modulo 2^16
  assign fetching = (state != ST_HALT);

  // Read request decodes only registered state, never an input.
  assign i_rd_en = fetching;
  assign i_addr  = pc;

  // A redirect always squashes IF/ID; otherwise, when not stalled, a miss
  // or a halted front end inserts a bubble.
  assign ifid_bubble = redirect_en || (!stall_if && (!fetching || !i_rdy));
  assign ifid_load   = fetching && i_rdy;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc     <= 16'h0000;
      state  <= ST_RUN;
      halted <= 1'b0;
    end else if (redirect_en) begin
      pc     <= redirect_pc;
      state  <= ST_RUN;
      halted <= 1'b0;
    end else if (!stall_if) begin
      case (state)
        ST_RUN, ST_WAIT: begin
          if (i_rdy) begin
            if (is_hlt(i_data)) begin
              // The HLT itself goes to decode but the PC stays on it.
              state  <= ST_HALT;
              halted <= 1'b1;
            end else begin
              pc    <= pc_plus1;
              state <= ST_RUN;
            end
          end else begin
            state <= ST_WAIT;
          end
        end
        default: begin
          // HALT: only a redirect or reset leaves.
          state  <= ST_HALT;
          halted <= 1'b1;
        end
      endcase
    end
  end

  if_id_reg u_if_id_reg (
    .clk          (clk),
    .rst_n        (rst_n),
    .bubble       (ifid_bubble),
    .hold         (stall_if),
    .load         (ifid_load),
    .new_instr    (i_data),
    .new_pc_plus1 (pc_plus1),
    .instr        (if_id_instr),
    .pc_plus1     (if_id_pc_plus1),
    .valid        (if_id_valid)
  );

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n, stall_if, redirect_en, i_rdy;
  logic [15:0] redirect_pc, i_data;
  logic        i_rd_en, if_id_valid, halted;
  logic [15:0] i_addr, if_id_instr, if_id_pc_plus1;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall_if       (stall_if),
    .redirect_en    (redirect_en),
    .redirect_pc    (redirect_pc),
    .i_rdy          (i_rdy),
    .i_data         (i_data),
    .i_rd_en        (i_rd_en),
    .i_addr         (i_addr),
    .if_id_instr    (if_id_instr),
    .if_id_pc_plus1 (if_id_pc_plus1),
    .if_id_valid    (if_id_valid),
    .halted         (halted)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural model: PC, a halted flag and the IF/ID contents.
  logic [15:0] m_pc, m_instr, m_pc1;
  logic        m_valid, m_halt;

  typedef struct {
    logic        rst_n, stall, redir;
    logic [15:0] rpc;
    logic        rdy;
    logic [15:0] data;
    logic        chk_pre;
    logic [15:0] e_addr;
    logic        e_rden;
    logic [15:0] e_instr, e_pc1;
    logic        e_valid, e_halt;
  } vec_t;

  vec_t tbl[$];

  task automatic cmp(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input logic r, input logic s, input logic rd,
                            input logic [15:0] rp, input logic ry, input logic [15:0] d);
    if (!r) begin
      m_pc = 16'h0; m_halt = 1'b0; m_instr = 16'h0; m_pc1 = 16'h0; m_valid = 1'b0;
    end else if (rd) begin
      m_pc = rp; m_halt = 1'b0; m_instr = 16'h0; m_valid = 1'b0;
    end else if (s) begin
      // everything holds
    end else if (m_halt || !ry) begin
      m_instr = 16'h0; m_valid = 1'b0;
    end else begin
      m_instr = d; m_pc1 = m_pc + 16'd1; m_valid = 1'b1;
      if (d[15:12] == 4'hF) m_halt = 1'b1;
      else m_pc = m_pc + 16'd1;
    end
  endtask

  task automatic drive(input logic r, input logic s, input logic rd,
                       input logic [15:0] rp, input logic ry, input logic [15:0] d);
    rst_n = r; stall_if = s; redirect_en = rd; redirect_pc = rp; i_rdy = ry; i_data = d;
  endtask

  function automatic vec_t mk(input logic r, input logic s, input logic rd, input logic [15:0] rp,
                              input logic ry, input logic [15:0] d, input logic cp,
                              input logic [15:0] ea, input logic er, input logic [15:0] ei,
                              input logic [15:0] ep, input logic ev, input logic eh);
    vec_t v;
    v.rst_n = r; v.stall = s; v.redir = rd; v.rpc = rp; v.rdy = ry; v.data = d;
    v.chk_pre = cp; v.e_addr = ea; v.e_rden = er;
    v.e_instr = ei; v.e_pc1 = ep; v.e_valid = ev; v.e_halt = eh;
    return v;
  endfunction

  initial begin
    drive(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0);
    m_pc = 16'h0; m_instr = 16'h0; m_pc1 = 16'h0; m_valid = 1'b0; m_halt = 1'b0;

    //            rst stl red rpc      rdy data     pre addr    rden instr    pc1      v  h
    // reset, then two hits
    tbl.push_back(mk(0, 0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 16'h0000, 0, 0));
    tbl.push_back(mk(1, 0, 0, 16'h0000, 1, 16'h1123, 1, 16'h0000, 1, 16'h1123, 16'h0001, 1, 0));
    tbl.push_back(mk(1, 0, 0, 16'h0000, 1, 16'h2456, 1, 16'h0001, 1, 16'h2456, 16'h0002, 1, 0));
    // redirect to 5, three misses, then hit
    tbl.push_back(mk(1, 0, 1, 16'h0005, 0, 16'h0000, 1, 16'h0002, 1, 16'h0000, 16'h0002, 0, 0));
    tbl.push_back(mk(1, 0, 0, 16'h0000, 0, 16'h3000, 1, 16'h0005, 1, 16'h0000, 16'h0002, 0, 0));
    tbl.push_back(mk(1, 0, 0, 16'h0000, 0, 16'h3000, 1, 16'h0005, 1, 16'h0000, 16'h0002, 0, 0));
    tbl.push_back(mk(1, 0, 0, 16'h0000, 0, 16'h3000, 1, 16'h0005, 1, 16'h0000, 16'h0002, 0, 0));
    tbl.push_back(mk(1, 0, 0, 16'h0000, 1, 16'h3abc, 1, 16'h0005, 1, 16'h3abc, 16'h0006, 1, 0));
    // reach PC=8, stall twice, then stall+redirect to 0x40
    tbl.push_back(mk(1, 0, 1, 16'h0007, 1, 16'h0000, 1, 16'h0006, 1, 16'h0000, 16'h0006, 0, 0));
    tbl.push_back(mk(1, 0, 0, 16'h0000, 1, 16'h4001, 1, 16'h0007, 1, 16'h4001, 16'h0008, 1, 0));
    tbl.push_back(mk(1, 1, 0, 16'h0000, 1, 16'h5555, 1, 16'h0008, 1, 16'h4001, 16'h0008, 1, 0));
    tbl.push_back(mk(1, 1, 0, 16'h0000, 0, 16'h5555, 1, 16'h0008, 1, 16'h4001, 16'h0008, 1, 0));
    tbl.push_back(mk(1, 1, 1, 16'h0040, 1, 16'h5555, 1, 16'h0008, 1, 16'h0000, 16'h0008, 0, 0));
    tbl.push_back(mk(1, 0, 0, 16'h0000, 1, 16'h6666, 1, 16'h0040, 1, 16'h6666, 16'h0041, 1, 0));
    // HLT at 0x10, halted, stalled in HALT, redirect to 0x20
    tbl.push_back(mk(1, 0, 1, 16'h0010, 1, 16'h0000, 1, 16'h0041, 1, 16'h0000, 16'h0041, 0, 0));
    tbl.push_back(mk(1, 0, 0, 16'h0000, 1, 16'hF000, 1, 16'h0010, 1, 16'hF000, 16'h0011, 1, 1));
    tbl.push_back(mk(1, 0, 0, 16'h0000, 1, 16'h1111, 1, 16'h0010, 0, 16'h0000, 16'h0011, 0, 1));
    tbl.push_back(mk(1, 1, 0, 16'h0000, 1, 16'h1111, 1, 16'h0010, 0, 16'h0000, 16'h0011, 0, 1));
    tbl.push_back(mk(1, 0, 1, 16'h0020, 0, 16'h1111, 1, 16'h0010, 0, 16'h0000, 16'h0011, 0, 0));
    tbl.push_back(mk(1, 0, 0, 16'h0000, 1, 16'h2222, 1, 16'h0020, 1, 16'h2222, 16'h0021, 1, 0));
    // PC wrap at 0xFFFF, then miss (WAIT), reset during WAIT
    tbl.push_back(mk(1, 0, 1, 16'hFFFF, 0, 16'h0000, 1, 16'h0021, 1, 16'h0000, 16'h0021, 0, 0));
    tbl.push_back(mk(1, 0, 0, 16'h0000, 1, 16'h7777, 1, 16'hFFFF, 1, 16'h7777, 16'h0000, 1, 0));
    tbl.push_back(mk(1, 0, 0, 16'h0000, 0, 16'h7777, 1, 16'h0000, 1, 16'h0000, 16'h0000, 0, 0));
    tbl.push_back(mk(0, 1, 1, 16'h1234, 1, 16'h8888, 1, 16'h0000, 1, 16'h0000, 16'h0000, 0, 0));
    tbl.push_back(mk(1, 0, 0, 16'h0000, 1, 16'h9999, 1, 16'h0000, 1, 16'h9999, 16'h0001, 1, 0));
    // reset during HALT
    tbl.push_back(mk(1, 0, 1, 16'h0030, 0, 16'h0000, 1, 16'h0001, 1, 16'h0000, 16'h0001, 0, 0));
    tbl.push_back(mk(1, 0, 0, 16'h0000, 1, 16'hF123, 1, 16'h0030, 1, 16'hF123, 16'h0031, 1, 1));
    tbl.push_back(mk(0, 0, 0, 16'h0000, 1, 16'h0001, 1, 16'h0030, 0, 16'h0000, 16'h0000, 0, 0));
    tbl.push_back(mk(1, 0, 0, 16'h0000, 0, 16'h0001, 1, 16'h0000, 1, 16'h0000, 16'h0000, 0, 0));

    foreach (tbl[i]) begin
      drive(tbl[i].rst_n, tbl[i].stall, tbl[i].redir, tbl[i].rpc, tbl[i].rdy, tbl[i].data);
      #1;
      if (tbl[i].chk_pre) begin
        cmp($sformatf("vec%0d i_addr", i), i_addr, tbl[i].e_addr);
        cmp($sformatf("vec%0d i_rd_en", i), {15'b0, i_rd_en}, {15'b0, tbl[i].e_rden});
      end
      model_step(tbl[i].rst_n, tbl[i].stall, tbl[i].redir, tbl[i].rpc, tbl[i].rdy, tbl[i].data);
      @(posedge clk);
      #1;
      cmp($sformatf("vec%0d instr", i), if_id_instr, tbl[i].e_instr);
      cmp($sformatf("vec%0d pc_plus1", i), if_id_pc_plus1, tbl[i].e_pc1);
      cmp($sformatf("vec%0d valid", i), {15'b0, if_id_valid}, {15'b0, tbl[i].e_valid});
      cmp($sformatf("vec%0d halted", i), {15'b0, halted}, {15'b0, tbl[i].e_halt});
      $display("vec %0d: addr=%h instr=%h pc1=%h v=%0d h=%0d", i, i_addr, if_id_instr,
               if_id_pc_plus1, if_id_valid, halted);
    end

    // Randomized run against the model (model state continues from the table).
    for (int k = 0; k < 400; k++) begin
      logic        r, s, rd, ry;
      logic [15:0] rp, d;
      r  = ($urandom_range(0, 39) != 0);
      rd = ($urandom_range(0, 7) == 0);
      s  = ($urandom_range(0, 3) == 0);
      ry = ($urandom_range(0, 3) != 0);
      rp = ($urandom_range(0, 5) == 0) ? 16'hFFFF : 16'($urandom);
      d  = 16'($urandom);
      drive(r, s, rd, rp, ry, d);
      #1;
      cmp($sformatf("rnd%0d i_addr", k), i_addr, m_pc);
      cmp($sformatf("rnd%0d i_rd_en", k), {15'b0, i_rd_en}, {15'b0, !m_halt});
      model_step(r, s, rd, rp, ry, d);
      @(posedge clk);
      #1;
      cmp($sformatf("rnd%0d instr", k), if_id_instr, m_instr);
      cmp($sformatf("rnd%0d pc_plus1", k), if_id_pc_plus1, m_pc1);
      cmp($sformatf("rnd%0d valid", k), {15'b0, if_id_valid}, {15'b0, m_valid});
      cmp($sformatf("rnd%0d halted", k), {15'b0, halted}, {15'b0, m_halt});
      $display("rnd %0d: rst_n=%0d stall=%0d redir=%0d rdy=%0d data=%h -> instr=%h pc1=%h v=%0d h=%0d",
               k, r, s, rd, ry, d, if_id_instr, if_id_pc_plus1, if_id_valid, halted);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Clock and reset: one clock; reset is synchronous and active-low.
REQ-002 clk  input  1  pipeline clock; all state updates on rising edge.
REQ-003 rst_n  input  1  synchronous active-low reset.
REQ-004 stall_if  input  1  hazard stall; hold PC and IF/ID register.
REQ-005 redirect_en  input  1  taken branch/jump resolved downstream; load redirect_pc.
REQ-006 redirect_pc  input  16  redirect target word address.
REQ-007 i_rdy  input  1  instruction cache hit; i_data valid this cycle.
REQ-008 i_data  input  16  instruction word for i_addr.
REQ-009 i_rd_en  output  1  instruction read request.
REQ-010 i_addr  output  16  instruction word address, equal to PC.
REQ-011 if_id_instr  output  16  registered instruction to the decode stage.
REQ-012 if_id_pc_plus1  output  16  registered PC+1 of if_id_instr.
REQ-013 if_id_valid  output  1  if_id_instr is a real instruction, not a bubble.
REQ-014 halted  output  1  fetch stopped after an HLT was fetched.

Function
REQ-015 The FSM SHALL have exactly three states: RUN, WAIT (cache miss), HALT.
REQ-016 In RUN and WAIT, i_rd_en SHALL be 1 and i_addr SHALL equal PC; in HALT, i_rd_en SHALL be 0.
REQ-017 Priority SHALL be redirect_en > stall_if > i_rdy, in every state.
REQ-018 redirect_en SHALL load PC<=redirect_pc, set if_id_valid<=0 and if_id_instr<=16'h0000, and move to RUN from any state, stalled or not.
REQ-019 With stall_if=1 and no redirect, PC, state and all if_id_* outputs SHALL hold.
REQ-020 RUN, no stall, i_rdy=1: IF/ID<=(i_data, PC+1, valid=1), PC<=PC+1, stay in RUN.
REQ-021 RUN, no stall, i_rdy=0: go to WAIT, PC held, if_id_valid<=0 (bubble).
REQ-022 WAIT, no stall: i_rdy=1 behaves as REQ-020 and returns to RUN; i_rdy=0 stays in WAIT and writes a bubble.
REQ-023 When an instruction is latched whose i_data[15:12] equals the shared HLT opcode, it SHALL enter IF/ID normally, PC SHALL NOT advance, and the FSM SHALL go to HALT.
REQ-024 In HALT, PC SHALL be frozen, halted SHALL be 1, and IF/ID SHALL take bubbles when not stalled; only redirect_en leaves HALT, because the HLT may be wrong-path.
REQ-025 PC+1 SHALL wrap modulo 2^16 (16'hFFFF -> 16'h0000) with no flag.
REQ-026 halted SHALL be a registered output, 1 exactly while the state is HALT.

Reset
REQ-027 On rst_n=0 at a clock edge: PC=16'h0000, state=RUN, if_id_instr=16'h0000, if_id_pc_plus1=16'h0000, if_id_valid=0, halted=0.
REQ-028 Reset SHALL override redirect_en, stall_if and i_rdy, and abort a WAIT or HALT with no residual state.
REQ-029 i_rd_en SHALL be 1 in the first cycle after reset release, with i_addr=16'h0000.

Structure
REQ-030 Opcode constants (HLT) SHALL come from the shared defines file; the FSM state encodings and the bubble value 16'h0000 SHALL be defined there as well.
REQ-031 The IF/ID register (instr, pc_plus1, valid, with hold and bubble controls) SHALL be a sub-module named if_id_reg; the PC and FSM SHALL stay in fetch_unit.
REQ-032 All outputs except i_addr and i_rd_en SHALL be registered; i_addr and i_rd_en SHALL decode only PC and state, with no path from any input.

Verification
REQ-033 Reset, then i_rdy=1 with words 0x1123, 0x2456 -> i_addr 0,1,2; if_id_pc_plus1 1,2; if_id_valid=1 from the 2nd cycle.
REQ-034 PC=5 with i_rdy=0 for 3 cycles, then 1 -> three bubbles, i_addr held at 5, then instr latched with pc_plus1=6.
REQ-035 stall_if=1 for 2 cycles at PC=8 -> PC and if_id_* unchanged; stall plus redirect_en to 0x0040 in the same cycle -> PC=0x0040, if_id_valid=0.
REQ-036 HLT fetched at PC=0x10 -> HLT in IF/ID, halted=1 next cycle, i_rd_en=0, PC stays 0x10; a later redirect to 0x20 -> RUN, fetch at 0x20.
REQ-037 PC=16'hFFFF hit -> if_id_pc_plus1=0x0000, next i_addr=0x0000; rst_n=0 during WAIT -> REQ-027 values next cycle.
